// File: rtl/argmax_camada_if.sv
// Bus between the neural-network layer / result consumer and argmax_camada.
// Carries the captured layer outputs, the capture trigger and neuron count,
// and the valid/ack result handshake with its status flags.
interface argmax_camada_if #(
    parameter int N = 8
);
    logic [N-1:0] iR [0:19];
    logic         iFlagCamada;
    logic [4:0]   iQtdNeuronios;
    logic         iAck;
    logic [4:0]   oClasse;
    logic [N-1:0] oValor;
    logic         oValido;
    logic         oOcupado;
    logic         oPerdido;

    // Layer and consumer side: drives the layer outputs, flag, count and ack.
    modport master (
        output iR, iFlagCamada, iQtdNeuronios, iAck,
        input  oClasse, oValor, oValido, oOcupado, oPerdido
    );

    // argmax_camada side.
    modport slave (
        input  iR, iFlagCamada, iQtdNeuronios, iAck,
        output oClasse, oValor, oValido, oOcupado, oPerdido
    );
endinterface

// File: rtl/argmax_camada.sv
// argmax_camada: captures 20 neuron outputs on a rising edge of the layer-done
// flag, scans the first qtd of them with a single comparator (one word per
// cycle) and presents the index/value of the largest through valid/ack.
// Ties keep the lower index. Flag edges seen while busy are reported on
// oPerdido and otherwise ignored.
module argmax_camada #(
    parameter int N     = 8,
    parameter int SINAL = 1
) (
    input  logic               clk,
    input  logic               iRst,
    argmax_camada_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_r;
    state_t       state_nxt_s;

    logic         flag_d;
    logic [N-1:0] buf_r [0:19];
    logic [4:0]   qtd_r;
    logic [N-1:0] max_r;
    logic [4:0]   idx_r;
    logic [4:0]   i_r;

    logic [4:0]   classe_r;
    logic [N-1:0] valor_r;
    logic         valido_r;
    logic         perdido_r;

    logic         rise_s;
    logic [4:0]   qtd_in_s;
    logic         maior_s;
    logic [N-1:0] max_nxt_s;
    logic [4:0]   idx_nxt_s;
    logic         scan_fim_s;

    // Strict "a greater than b" under the configured number format.
    function automatic logic maior(input logic [N-1:0] a, input logic [N-1:0] b);
        logic r;
        if (SINAL != 0) begin
            r = ($signed(a) > $signed(b));
        end else begin
            r = (a > b);
        end
        return r;
    endfunction

    // Edge detect, count clamping and the single-comparator scan step.
    always_comb begin
        rise_s = bus.iFlagCamada & ~flag_d;

        if (bus.iQtdNeuronios == 5'd0) begin
            qtd_in_s = 5'd1;
        end else if (bus.iQtdNeuronios > 5'd20) begin
            qtd_in_s = 5'd20;
        end else begin
            qtd_in_s = bus.iQtdNeuronios;
        end

        maior_s = maior(buf_r[i_r], max_r);
        if (maior_s) begin
            max_nxt_s = buf_r[i_r];
            idx_nxt_s = i_r;
        end else begin
            max_nxt_s = max_r;
            idx_nxt_s = idx_r;
        end

        scan_fim_s = (i_r == (qtd_r - 5'd1));
    end

    // Next-state logic of the IDLE/SCAN/DONE controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    if (qtd_in_s == 5'd1) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = SCAN;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SCAN: begin
                if (scan_fim_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SCAN;
                end
            end
            DONE: begin
                if (bus.iAck) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture buffer, scan registers and registered result outputs.
    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            flag_d    <= 1'b0;
            qtd_r     <= 5'd0;
            max_r     <= '0;
            idx_r     <= 5'd0;
            i_r       <= 5'd0;
            classe_r  <= 5'd0;
            valor_r   <= '0;
            valido_r  <= 1'b0;
            perdido_r <= 1'b0;
            for (int k = 0; k < 20; k++) begin
                buf_r[k] <= '0;
            end
        end else begin
            flag_d    <= bus.iFlagCamada;
            perdido_r <= rise_s && (state_r != IDLE);
            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        for (int k = 0; k < 20; k++) begin
                            buf_r[k] <= bus.iR[k];
                        end
                        qtd_r <= qtd_in_s;
                        max_r <= bus.iR[0];
                        idx_r <= 5'd0;
                        i_r   <= 5'd1;
                        // A single neuron is its own maximum: present at once.
                        if (qtd_in_s == 5'd1) begin
                            classe_r <= 5'd0;
                            valor_r  <= bus.iR[0];
                            valido_r <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    max_r <= max_nxt_s;
                    idx_r <= idx_nxt_s;
                    i_r   <= i_r + 5'd1;
                    // Last word processed: publish including this step's result.
                    if (scan_fim_s) begin
                        classe_r <= idx_nxt_s;
                        valor_r  <= max_nxt_s;
                        valido_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.iAck) begin
                        valido_r <= 1'b0;
                    end
                end
                default: begin
                    valido_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oClasse  = classe_r;
    assign bus.oValor   = valor_r;
    assign bus.oValido  = valido_r;
    assign bus.oPerdido = perdido_r;
    assign bus.oOcupado = (state_r == SCAN) || (state_r == DONE);

endmodule

// File: tb/tb_argmax_camada.sv
// Directed bench for argmax_camada: a signed and an unsigned instance share
// clock, reset and stimulus; each scenario task checks its own results.
module tb_argmax_camada;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    argmax_camada_if #(.N(8)) bus_s ();
    argmax_camada_if #(.N(8)) bus_u ();

    argmax_camada #(.N(8), .SINAL(1)) dut_s (.clk(clk), .iRst(rst), .bus(bus_s));
    argmax_camada #(.N(8), .SINAL(0)) dut_u (.clk(clk), .iRst(rst), .bus(bus_u));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_r(input int k, input logic [7:0] v);
        bus_s.iR[k] = v;
        bus_u.iR[k] = v;
    endtask

    task automatic set_all(input logic [7:0] v);
        for (int k = 0; k < 20; k++) set_r(k, v);
    endtask

    task automatic set_flag(input logic b);
        bus_s.iFlagCamada = b;
        bus_u.iFlagCamada = b;
    endtask

    task automatic set_ack(input logic b);
        bus_s.iAck = b;
        bus_u.iAck = b;
    endtask

    task automatic capture(input logic [4:0] q);
        bus_s.iQtdNeuronios = q;
        bus_u.iQtdNeuronios = q;
        set_flag(1'b1);
        tick();
        set_flag(1'b0);
    endtask

    task automatic wait_valido(output int lat);
        lat = 0;
        while (!bus_s.oValido && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_ack();
        set_ack(1'b1);
        tick();
        set_ack(1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_all(8'h00);
        set_flag(1'b0);
        set_ack(1'b0);
        bus_s.iQtdNeuronios = 5'd0;
        bus_u.iQtdNeuronios = 5'd0;
        #1;
        vectors++;
        if ({bus_s.oClasse, bus_s.oValor, bus_s.oValido, bus_s.oOcupado, bus_s.oPerdido} !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_outputs: got cls=%0d val=%h vld=%b ocp=%b prd=%b, expected all 0",
                     bus_s.oClasse, bus_s.oValor, bus_s.oValido, bus_s.oOcupado, bus_s.oPerdido);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        vectors++;
        if (bus_s.oOcupado !== 1'b0 || bus_s.oValido !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got ocp=%b vld=%b, expected 0 0", bus_s.oOcupado, bus_s.oValido);
        end
    endtask

    task automatic test_basic();
        int lat;
        for (int k = 0; k < 20; k++) set_r(k, 8'(k));
        set_r(13, 8'h7F);
        capture(5'd20);
        vectors++;
        if (bus_s.oOcupado !== 1'b1 || bus_s.oValido !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_busy: got ocp=%b vld=%b, expected 1 0", bus_s.oOcupado, bus_s.oValido);
        end
        wait_valido(lat);
        vectors++;
        if (lat !== 19) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d expected 19", lat);
        end
        vectors++;
        if (bus_s.oClasse !== 5'd13 || bus_s.oValor !== 8'h7F) begin
            miscompares++;
            $display("FAIL basic_result: got cls=%0d val=%h expected cls=13 val=7f", bus_s.oClasse, bus_s.oValor);
        end
        do_ack();
        vectors++;
        if (bus_s.oValido !== 1'b0 || bus_s.oOcupado !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_ack: got vld=%b ocp=%b expected 0 0", bus_s.oValido, bus_s.oOcupado);
        end
        vectors++;
        if (bus_s.oClasse !== 5'd13 || bus_s.oValor !== 8'h7F) begin
            miscompares++;
            $display("FAIL basic_hold_after_ack: got cls=%0d val=%h expected 13 7f", bus_s.oClasse, bus_s.oValor);
        end
    endtask

    task automatic test_signed_ties();
        int lat;
        set_all(8'h80);
        set_r(4, 8'hFF);
        set_r(9, 8'hFF);
        capture(5'd20);
        wait_valido(lat);
        vectors++;
        if (bus_s.oClasse !== 5'd4 || bus_s.oValor !== 8'hFF) begin
            miscompares++;
            $display("FAIL signed_tie: got cls=%0d val=%h expected cls=4 val=ff", bus_s.oClasse, bus_s.oValor);
        end
        vectors++;
        if (bus_u.oClasse !== 5'd4 || bus_u.oValor !== 8'hFF) begin
            miscompares++;
            $display("FAIL unsigned_tie: got cls=%0d val=%h expected cls=4 val=ff", bus_u.oClasse, bus_u.oValor);
        end
        do_ack();
    endtask

    task automatic test_unsigned();
        int lat;
        set_all(8'h10);
        set_r(2, 8'h80);
        capture(5'd20);
        wait_valido(lat);
        vectors++;
        if (bus_u.oClasse !== 5'd2 || bus_u.oValor !== 8'h80) begin
            miscompares++;
            $display("FAIL unsigned_max: got cls=%0d val=%h expected cls=2 val=80", bus_u.oClasse, bus_u.oValor);
        end
        // Same data read as signed: 0x80 is -128, so the first 0x10 wins.
        vectors++;
        if (bus_s.oClasse !== 5'd0 || bus_s.oValor !== 8'h10) begin
            miscompares++;
            $display("FAIL signed_view: got cls=%0d val=%h expected cls=0 val=10", bus_s.oClasse, bus_s.oValor);
        end
        do_ack();
    endtask

    task automatic test_count_limits();
        int lat;
        for (int k = 0; k < 20; k++) set_r(k, 8'(k + 1));
        capture(5'd1);
        wait_valido(lat);
        vectors++;
        if (lat !== 0 || bus_s.oClasse !== 5'd0 || bus_s.oValor !== 8'h01) begin
            miscompares++;
            $display("FAIL qtd1: got lat=%0d cls=%0d val=%h expected 0 0 01", lat, bus_s.oClasse, bus_s.oValor);
        end
        do_ack();
        set_r(0, 8'h05);
        capture(5'd0);
        wait_valido(lat);
        vectors++;
        if (lat !== 0 || bus_s.oClasse !== 5'd0 || bus_s.oValor !== 8'h05) begin
            miscompares++;
            $display("FAIL qtd0: got lat=%0d cls=%0d val=%h expected 0 0 05", lat, bus_s.oClasse, bus_s.oValor);
        end
        do_ack();
        for (int k = 0; k < 20; k++) set_r(k, 8'(k));
        set_r(19, 8'h50);
        capture(5'd25);
        wait_valido(lat);
        vectors++;
        if (lat !== 19 || bus_s.oClasse !== 5'd19 || bus_s.oValor !== 8'h50) begin
            miscompares++;
            $display("FAIL qtd25: got lat=%0d cls=%0d val=%h expected 19 19 50", lat, bus_s.oClasse, bus_s.oValor);
        end
        do_ack();
        set_all(8'h00);
        set_r(0, 8'h03);
        set_r(1, 8'h09);
        set_r(2, 8'h02);
        set_r(3, 8'h09);
        set_r(4, 8'h01);
        set_r(7, 8'h7F);
        capture(5'd5);
        wait_valido(lat);
        vectors++;
        if (lat !== 4 || bus_s.oClasse !== 5'd1 || bus_s.oValor !== 8'h09) begin
            miscompares++;
            $display("FAIL qtd5: got lat=%0d cls=%0d val=%h expected 4 1 09", lat, bus_s.oClasse, bus_s.oValor);
        end
        do_ack();
    endtask

    task automatic test_busy_handshake();
        int lat;
        for (int k = 0; k < 20; k++) set_r(k, 8'(k));
        set_r(10, 8'h60);
        capture(5'd20);
        // Inputs change after capture; only the buffer may count.
        set_all(8'h7F);
        tick();
        tick();
        set_flag(1'b1);
        tick();
        set_flag(1'b0);
        vectors++;
        if (bus_s.oPerdido !== 1'b1) begin
            miscompares++;
            $display("FAIL lost_pulse: got %b expected 1", bus_s.oPerdido);
        end
        tick();
        vectors++;
        if (bus_s.oPerdido !== 1'b0) begin
            miscompares++;
            $display("FAIL lost_pulse_width: got %b expected 0", bus_s.oPerdido);
        end
        wait_valido(lat);
        vectors++;
        if (bus_s.oClasse !== 5'd10 || bus_s.oValor !== 8'h60 || lat !== 15) begin
            miscompares++;
            $display("FAIL busy_result: got cls=%0d val=%h lat=%0d expected 10 60 15", bus_s.oClasse, bus_s.oValor, lat);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            vectors++;
            if (bus_s.oValido !== 1'b1 || bus_s.oClasse !== 5'd10) begin
                miscompares++;
                $display("FAIL valid_hold[%0d]: got vld=%b cls=%0d expected 1 10", c, bus_s.oValido, bus_s.oClasse);
            end
        end
        set_flag(1'b1);
        tick();
        vectors++;
        if (bus_s.oPerdido !== 1'b1 || bus_s.oValido !== 1'b1) begin
            miscompares++;
            $display("FAIL lost_in_done: got prd=%b vld=%b expected 1 1", bus_s.oPerdido, bus_s.oValido);
        end
        do_ack();
        tick();
        tick();
        tick();
        vectors++;
        if (bus_s.oOcupado !== 1'b0 || bus_s.oValido !== 1'b0) begin
            miscompares++;
            $display("FAIL no_retrigger: got ocp=%b vld=%b expected 0 0", bus_s.oOcupado, bus_s.oValido);
        end
        set_flag(1'b0);
        tick();
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        for (int k = 0; k < 20; k++) set_r(k, 8'(k));
        set_r(6, 8'h33);
        capture(5'd20);
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus_s.oClasse, bus_s.oValor, bus_s.oValido, bus_s.oOcupado, bus_s.oPerdido} !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_mid_scan: got cls=%0d val=%h vld=%b ocp=%b prd=%b expected all 0",
                     bus_s.oClasse, bus_s.oValor, bus_s.oValido, bus_s.oOcupado, bus_s.oPerdido);
        end
        tick();
        rst = 1'b0;
        tick();
        vectors++;
        if (bus_s.oValido !== 1'b0 || bus_s.oOcupado !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_result: got vld=%b ocp=%b expected 0 0", bus_s.oValido, bus_s.oOcupado);
        end
        capture(5'd20);
        wait_valido(lat);
        vectors++;
        if (lat !== 19 || bus_s.oClasse !== 5'd6 || bus_s.oValor !== 8'h33) begin
            miscompares++;
            $display("FAIL after_reset: got lat=%0d cls=%0d val=%h expected 19 6 33", lat, bus_s.oClasse, bus_s.oValor);
        end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed_ties();
        test_unsigned();
        test_count_limits();
        test_busy_handshake();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
